// File: rtl/id_ex_stage_pkg.sv
// Shared types and widths for the ID/EX pipeline register and its hazard unit.
package id_ex_stage_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned IMLEN = 32;

    typedef enum logic [3:0] {
        AluAdd  = 4'd0,
        AluSub  = 4'd1,
        AluAnd  = 4'd2,
        AluOr   = 4'd3,
        AluXor  = 4'd4,
        AluSll  = 4'd5,
        AluSrl  = 4'd6,
        AluSra  = 4'd7,
        AluSlt  = 4'd8,
        AluSltu = 4'd9
    } alu_ctrl_t;

    // Everything the EX stage consumes, held in one pipeline register.
    typedef struct packed {
        logic             valid;
        logic             alu_src;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
        alu_ctrl_t        alu_ctrl;
        logic [4:0]       rd;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [XLEN-1:0]  rs1_data;
        logic [XLEN-1:0]  rs2_data;
        logic [IMLEN-1:0] imm;
    } id_ex_t;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection: the instruction in EX is a load whose destination
// is read by the instruction currently in decode.
module hazard_detect (
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs2,
    output logic       hazard
);

    // x0 is never a real producer, so a load to it cannot create a dependency.
    always_comb begin
        hazard = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid &
                 ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush, hold and a
// saturating bubble counter.
module id_ex_stage #(
    parameter int unsigned XLEN  = id_ex_stage_pkg::XLEN,
    parameter int unsigned IMLEN = id_ex_stage_pkg::IMLEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_uses_rs2,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [IMLEN-1:0] id_imm,
    input  logic             id_alu_src,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic [3:0]       id_alu_ctrl,
    input  logic             flush,
    input  logic             hold,
    output logic             stall_if_id,
    output logic             ex_valid,
    output logic             ex_alu_src,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic [3:0]       ex_alu_ctrl,
    output logic [4:0]       ex_rd,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [IMLEN-1:0] ex_imm,
    output logic [15:0]      bubble_count
);

    import id_ex_stage_pkg::*;

    id_ex_t      ex_q;
    id_ex_t      capture;
    logic        hazard;
    logic [15:0] bubble_count_q;

    hazard_detect u_hazard_detect (
        .ex_valid    (ex_q.valid),
        .ex_mem_read (ex_q.mem_read),
        .ex_rd       (ex_q.rd),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs2 (id_uses_rs2),
        .hazard      (hazard)
    );

    // A flush squashes the requester anyway, so never freeze the front end then.
    always_comb begin
        stall_if_id = hazard & ~flush & ~rst;
    end

    // Payload taken from decode; controls are masked for an empty decode slot.
    always_comb begin
        capture           = '0;
        capture.valid     = id_valid;
        capture.alu_src   = id_alu_src & id_valid;
        capture.reg_write = id_reg_write & id_valid;
        capture.mem_read  = id_mem_read & id_valid;
        capture.mem_write = id_mem_write & id_valid;
        capture.alu_ctrl  = alu_ctrl_t'(id_alu_ctrl);
        capture.rd        = id_rd;
        capture.rs1       = id_rs1;
        capture.rs2       = id_rs2;
        capture.rs1_data  = id_rs1_data;
        capture.rs2_data  = id_rs2_data;
        capture.imm       = id_imm;
    end

    // Pipeline register and bubble counter: rst > flush > hold > hazard > capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q           <= '0;
            bubble_count_q <= '0;
        end else if (flush) begin
            ex_q <= '0;
        end else if (hold) begin
            ex_q <= ex_q;
        end else if (hazard) begin
            // The bubble clears mem_read, so the same dependency cannot stall twice.
            ex_q <= '0;
            if (bubble_count_q != 16'hFFFF) begin
                bubble_count_q <= bubble_count_q + 16'd1;
            end
        end else begin
            ex_q <= capture;
        end
    end

    assign ex_valid     = ex_q.valid;
    assign ex_alu_src   = ex_q.alu_src;
    assign ex_reg_write = ex_q.reg_write;
    assign ex_mem_read  = ex_q.mem_read;
    assign ex_mem_write = ex_q.mem_write;
    assign ex_alu_ctrl  = ex_q.alu_ctrl;
    assign ex_rd        = ex_q.rd;
    assign ex_rs1       = ex_q.rs1;
    assign ex_rs2       = ex_q.rs2;
    assign ex_rs1_data  = ex_q.rs1_data;
    assign ex_rs2_data  = ex_q.rs2_data;
    assign ex_imm       = ex_q.imm;
    assign bubble_count = bubble_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_id_ex_stage;

    localparam int XLEN  = 32;
    localparam int IMLEN = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic             id_uses_rs2;
    logic [XLEN-1:0]  id_rs1_data, id_rs2_data;
    logic [IMLEN-1:0] id_imm;
    logic             id_alu_src, id_reg_write, id_mem_read, id_mem_write;
    logic [3:0]       id_alu_ctrl;
    logic             flush, hold;
    logic             stall_if_id;
    logic             ex_valid, ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [3:0]       ex_alu_ctrl;
    logic [4:0]       ex_rd, ex_rs1, ex_rs2;
    logic [XLEN-1:0]  ex_rs1_data, ex_rs2_data;
    logic [IMLEN-1:0] ex_imm;
    logic [15:0]      bubble_count;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .IMLEN(IMLEN)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_uses_rs2  (id_uses_rs2),
        .id_rs1_data  (id_rs1_data),
        .id_rs2_data  (id_rs2_data),
        .id_imm       (id_imm),
        .id_alu_src   (id_alu_src),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .id_mem_write (id_mem_write),
        .id_alu_ctrl  (id_alu_ctrl),
        .flush        (flush),
        .hold         (hold),
        .stall_if_id  (stall_if_id),
        .ex_valid     (ex_valid),
        .ex_alu_src   (ex_alu_src),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_alu_ctrl  (ex_alu_ctrl),
        .ex_rd        (ex_rd),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_rs1_data  (ex_rs1_data),
        .ex_rs2_data  (ex_rs2_data),
        .ex_imm       (ex_imm),
        .bubble_count (bubble_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: what the EX side should hold, plus the bubble total.
    logic             m_valid, m_alu_src, m_reg_write, m_mem_read, m_mem_write;
    logic [3:0]       m_alu_ctrl;
    logic [4:0]       m_rd, m_rs1, m_rs2;
    logic [XLEN-1:0]  m_rs1_data, m_rs2_data;
    logic [IMLEN-1:0] m_imm;
    int               m_count;

    task automatic model_clear();
        m_valid = 0; m_alu_src = 0; m_reg_write = 0; m_mem_read = 0; m_mem_write = 0;
        m_alu_ctrl = '0; m_rd = '0; m_rs1 = '0; m_rs2 = '0;
        m_rs1_data = '0; m_rs2_data = '0; m_imm = '0;
    endtask

    // Does decode read a register that the load in EX has not produced yet?
    function automatic bit model_depends();
        bit reads_rd;
        if (!(m_valid && m_mem_read && m_rd != 0 && id_valid)) return 0;
        reads_rd = (id_rs1 == m_rd) || (id_uses_rs2 && id_rs2 == m_rd);
        return reads_rd;
    endfunction

    task automatic model_edge();
        if (rst) begin
            model_clear();
            m_count = 0;
        end else if (flush) begin
            model_clear();
        end else if (hold) begin
            // nothing moves
        end else if (model_depends()) begin
            model_clear();
            m_count = (m_count < 65535) ? m_count + 1 : 65535;
        end else begin
            m_valid     = id_valid;
            m_alu_src   = id_valid ? id_alu_src : 1'b0;
            m_reg_write = id_valid ? id_reg_write : 1'b0;
            m_mem_read  = id_valid ? id_mem_read : 1'b0;
            m_mem_write = id_valid ? id_mem_write : 1'b0;
            m_alu_ctrl  = id_alu_ctrl;
            m_rd = id_rd; m_rs1 = id_rs1; m_rs2 = id_rs2;
            m_rs1_data = id_rs1_data; m_rs2_data = id_rs2_data; m_imm = id_imm;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ex_valid"},     ex_valid,     m_valid);
        chk({tag, ".ex_alu_src"},   ex_alu_src,   m_alu_src);
        chk({tag, ".ex_reg_write"}, ex_reg_write, m_reg_write);
        chk({tag, ".ex_mem_read"},  ex_mem_read,  m_mem_read);
        chk({tag, ".ex_mem_write"}, ex_mem_write, m_mem_write);
        chk({tag, ".ex_alu_ctrl"},  ex_alu_ctrl,  m_alu_ctrl);
        chk({tag, ".ex_rd"},        ex_rd,        m_rd);
        chk({tag, ".ex_rs1"},       ex_rs1,       m_rs1);
        chk({tag, ".ex_rs2"},       ex_rs2,       m_rs2);
        chk({tag, ".ex_rs1_data"},  ex_rs1_data,  m_rs1_data);
        chk({tag, ".ex_rs2_data"},  ex_rs2_data,  m_rs2_data);
        chk({tag, ".ex_imm"},       ex_imm,       m_imm);
        chk({tag, ".bubble_count"}, bubble_count, 64'(m_count));
    endtask

    // One clock: check the combinational stall, advance the model, check EX side.
    task automatic cycle(input string tag);
        #1;
        chk({tag, ".stall_if_id"}, stall_if_id, model_depends() && !flush && !rst);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic clear_id();
        rst = 0; flush = 0; hold = 0;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_uses_rs2 = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_alu_src = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_alu_ctrl = 0;
    endtask

    task automatic set_instr(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic uses, input logic mr);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_uses_rs2 = uses; id_mem_read = mr; id_reg_write = v;
    endtask

    typedef struct {
        logic       v;
        logic [4:0] rs1, rs2, rd;
        logic       uses, mr, fl;
        logic       e_stall, e_valid;
        logic [4:0] e_rd;
        logic       e_mr;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[10];
    logic [4:0] held_rd;

    initial begin
        // Sequence starting from a reset EX register; expectations hand-derived.
        vecs[0] = '{1, 1, 2, 5, 0, 1, 0,  0, 1, 5, 1, 0}; // lw x5
        vecs[1] = '{1, 3, 5, 6, 1, 0, 0,  1, 0, 0, 0, 1}; // add reads x5 -> bubble
        vecs[2] = '{1, 3, 5, 6, 1, 0, 0,  0, 1, 6, 0, 1}; // add now captured
        vecs[3] = '{1, 1, 2, 0, 0, 1, 0,  0, 1, 0, 1, 1}; // lw x0
        vecs[4] = '{1, 0, 0, 7, 1, 0, 0,  0, 1, 7, 0, 1}; // reads x0: no stall
        vecs[5] = '{1, 1, 2, 5, 0, 1, 0,  0, 1, 5, 1, 1}; // lw x5
        vecs[6] = '{1, 1, 5, 8, 0, 0, 0,  0, 1, 8, 0, 1}; // I-type, rs2 field unused
        vecs[7] = '{1, 1, 2, 9, 0, 1, 0,  0, 1, 9, 1, 1}; // lw x9
        vecs[8] = '{1, 9, 2, 3, 0, 0, 1,  0, 0, 0, 0, 1}; // hazard + flush
        vecs[9] = '{0, 9, 2, 4, 0, 1, 0,  0, 0, 4, 0, 1}; // empty slot, controls masked

        clear_id();
        model_clear();
        m_count = 0;
        rst = 1;
        cycle("reset");
        rst = 0;

        for (int i = 0; i < 10; i++) begin
            set_instr(vecs[i].v, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].uses, vecs[i].mr);
            flush = vecs[i].fl;
            #1;
            chk($sformatf("vec%0d.stall", i), stall_if_id, vecs[i].e_stall);
            model_edge();
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.ex_valid", i), ex_valid, vecs[i].e_valid);
            chk($sformatf("vec%0d.ex_rd", i), ex_rd, vecs[i].e_rd);
            chk($sformatf("vec%0d.ex_mem_read", i), ex_mem_read, vecs[i].e_mr);
            chk($sformatf("vec%0d.bubble_count", i), bubble_count, vecs[i].e_cnt);
        end
        clear_id();

        // Plain capture of a negative immediate with alu_src.
        id_valid = 1; id_rs1_data = 32'h0000_0005; id_imm = 32'hFFFF_FFFC; id_alu_src = 1;
        cycle("capture");
        chk("capture.rs1_data", ex_rs1_data, 32'h5);
        chk("capture.imm", ex_imm, 32'hFFFF_FFFC);
        chk("capture.alu_src", ex_alu_src, 1'b1);
        chk("capture.valid", ex_valid, 1'b1);

        // Hold for three cycles with decode changing underneath.
        clear_id();
        set_instr(1, 4, 6, 11, 1, 0);
        id_rs2_data = 32'hCAFE_0001;
        cycle("hold_load");
        held_rd = 5'd11;
        for (int i = 0; i < 3; i++) begin
            hold = 1;
            set_instr(1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                      5'(12 + i), 1, 1);
            id_rs2_data = $urandom;
            cycle("hold");
            chk("hold.ex_rd_kept", ex_rd, held_rd);
            chk("hold.rs2_data_kept", ex_rs2_data, 32'hCAFE_0001);
        end
        hold = 0;
        set_instr(1, 1, 2, 20, 0, 0);
        cycle("hold_release");
        chk("hold_release.ex_rd", ex_rd, 5'd20);

        // Reset during a stall discards the stalled add; it is captured afterwards.
        clear_id();
        set_instr(1, 1, 2, 7, 0, 1);
        cycle("rst_mid.lw");
        set_instr(1, 7, 0, 8, 0, 0);
        rst = 1;
        cycle("rst_mid.rst");
        chk("rst_mid.stall_low_in_reset", stall_if_id, 1'b0);
        rst = 0;
        cycle("rst_mid.after");
        chk("rst_mid.captured_rd", ex_rd, 5'd8);

        // Saturation: preset the counter just below the top, then two more bubbles.
        clear_id();
        hold = 1;
        #1;
        force dut.bubble_count_q = 16'hFFFE;
        #1;
        release dut.bubble_count_q;
        m_count = 65534;
        cycle("sat_preset");
        hold = 0;
        for (int i = 0; i < 2; i++) begin
            set_instr(1, 1, 2, 5, 0, 1);
            cycle("sat_lw");
            set_instr(1, 5, 2, 6, 0, 0);
            cycle("sat_bubble");
            chk("sat.count", bubble_count, 16'hFFFF);
        end
        rst = 1;
        cycle("sat_rst");
        chk("sat_rst.count", bubble_count, 16'h0);
        chk("sat_rst.valid", ex_valid, 1'b0);
        rst = 0;

        // Randomized traffic with a narrow register range to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            rst          = ($urandom_range(0, 63) == 0);
            flush        = ($urandom_range(0, 7) == 0);
            hold         = ($urandom_range(0, 7) == 0);
            id_valid     = ($urandom_range(0, 3) != 0);
            id_rs1       = 5'($urandom_range(0, 3));
            id_rs2       = 5'($urandom_range(0, 3));
            id_rd        = 5'($urandom_range(0, 3));
            id_uses_rs2  = 1'($urandom);
            id_mem_read  = 1'($urandom);
            id_mem_write = 1'($urandom);
            id_reg_write = 1'($urandom);
            id_alu_src   = 1'($urandom);
            id_alu_ctrl  = 4'($urandom);
            id_rs1_data  = $urandom;
            id_rs2_data  = $urandom;
            id_imm       = $urandom;
            cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width of register operands.
REQ-002 Parameter IMLEN, default 32, width of the immediate; it SHALL equal the ALU-source mux immediate width.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 id_valid  input  1  the decode slot holds a real instruction.
REQ-006 id_rs1, id_rs2, id_rd  input  5 each  decoded register indices.
REQ-007 id_uses_rs2  input  1  instruction reads rs2 (R/S/B type).
REQ-008 id_rs1_data, id_rs2_data  input  XLEN each  register-file read data.
REQ-009 id_imm  input  IMLEN  sign-extended immediate.
REQ-010 id_alu_src, id_reg_write, id_mem_read, id_mem_write  input  1 each  decoded controls.
REQ-011 id_alu_ctrl  input  4  ALU operation code.
REQ-012 flush  input  1  branch-taken squash from a later stage.
REQ-013 hold  input  1  external back-pressure; freeze this stage.
REQ-014 stall_if_id  output  1  combinational request to freeze PC and IF/ID (load-use).
REQ-015 ex_valid, ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write  output  1 each  registered controls.
REQ-016 ex_alu_ctrl  output  4; ex_rd, ex_rs1, ex_rs2  output  5 each; ex_rs1_data, ex_rs2_data  output  XLEN; ex_imm  output  IMLEN.
REQ-017 bubble_count  output  16  saturating count of inserted bubbles.

Function
REQ-018 The stage SHALL be a single-register stage: accepted ID values appear on ex_* exactly 1 cycle later.
REQ-019 Load-use hazard SHALL be detected as ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2))).
REQ-020 stall_if_id SHALL equal the hazard term, gated to 0 when flush or rst is high.
REQ-021 Per-edge priority SHALL be: rst > flush > hold > hazard > capture.
REQ-022 flush: ex_valid and all ex_* control bits SHALL become 0; data fields are don't-care but SHALL be zeroed.
REQ-023 hold (no flush): every ex_* register SHALL keep its value; bubble_count SHALL not change.
REQ-024 hazard (no flush/hold): a bubble SHALL be inserted (ex_valid=0, controls 0) and bubble_count incremented.
REQ-025 Otherwise all ex_* SHALL capture the id_* inputs, ex_valid = id_valid, and controls SHALL be forced to 0 when id_valid=0.
REQ-026 bubble_count SHALL saturate at 16'hFFFF, with no wrap-around.
REQ-027 A hazard against rd = x0 SHALL never stall.
REQ-028 Simultaneous flush and hazard SHALL produce a flush, with stall_if_id=0 and no count.
REQ-029 Back-to-back hazards SHALL resolve after one bubble, because the bubble clears ex_mem_read.

Reset
REQ-030 With rst high at an edge, all outputs SHALL be 0, including bubble_count; stall_if_id SHALL be 0 while rst is high.
REQ-031 Reset asserted mid-stall SHALL discard the pending instruction; on the first cycle after reset the stage SHALL capture normally.

Structure
REQ-032 A shared package SHALL hold XLEN, IMLEN, the 4-bit alu_ctrl_t enum, and a packed id_ex_t struct bundling all ex_* payload fields.
REQ-033 Hazard detection SHALL be one combinational sub-module, hazard_detect; the register and counter SHALL remain in id_ex_stage.

Verification
REQ-034 Capture: id_valid=1, rs1_data=0x0000_0005, imm=0xFFFF_FFFC, alu_src=1 -> next cycle ex_rs1_data=5, ex_imm=0xFFFF_FFFC, ex_alu_src=1, ex_valid=1.
REQ-035 Load-use: ex holds lw with rd=x5, ID add reads rs2=x5 -> stall_if_id=1, next ex_valid=0, bubble_count=1; following cycle the add is captured and stall_if_id=0.
REQ-036 x0 and unused rs2: lw rd=x0, or an ID I-type with rs2 field=5 and uses_rs2=0 -> stall_if_id=0 and no bubble.
REQ-037 Flush+hazard: hazard condition with flush=1 -> ex_valid=0, stall_if_id=0, bubble_count unchanged.
REQ-038 Hold: hold=1 for 3 cycles with changing id_* -> ex_* constant, then capture resumes on release.
REQ-039 Saturation/reset: preload bubble_count near 0xFFFF via 65535 hazards, one more hazard -> count stays 0xFFFF; rst pulse -> all outputs 0.
